// File: rtl/arp_pkg.sv
// Shared ARP constants and the receive FSM state encoding.
package arp_pkg;

  localparam int          ARP_HDR_LEN    = 28;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DROP = 2'd2
  } arp_rx_state_e;

endpackage

// File: rtl/arp_hdr_check.sv
// Combinational ARP header validation and target-IP filter decision.
module arp_hdr_check
  import arp_pkg::*;
#(
  parameter bit FILTER_ENABLE = 1'b1
) (
  input  logic [15:0] htype,
  input  logic [15:0] ptype,
  input  logic [7:0]  hlen,
  input  logic [7:0]  plen,
  input  logic [15:0] oper,
  input  logic [31:0] tpa,
  input  logic [31:0] local_ip,
  output logic        hdr_valid,
  output logic        tpa_match
);

  // Fixed-field check for Ethernet/IPv4 ARP; the filter passes everything when disabled.
  always_comb begin
    hdr_valid = (htype == ARP_HTYPE_ETH) && (ptype == ARP_PTYPE_IPV4) &&
                (hlen == 8'd6) && (plen == 8'd4) &&
                ((oper == ARP_OPER_REQ) || (oper == ARP_OPER_REPLY));
    tpa_match = !FILTER_ENABLE || (tpa == local_ip);
  end

endmodule

// File: rtl/arp_eth_rx_filter.sv
// ARP receiver: pulls the 28-byte header out of the payload stream, validates
// and filters it, and presents accepted frames on a parallel output.
module arp_eth_rx_filter
  import arp_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter bit KEEP_ENABLE   = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter bit FILTER_ENABLE = 1'b1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  input  logic [31:0]           local_ip,
  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [15:0]           m_arp_htype,
  output logic [15:0]           m_arp_ptype,
  output logic [7:0]            m_arp_hlen,
  output logic [7:0]            m_arp_plen,
  output logic [15:0]           m_arp_oper,
  output logic [47:0]           m_arp_sha,
  output logic [31:0]           m_arp_spa,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_tpa,
  output logic                  busy,
  output logic                  error_header_early_termination,
  output logic                  error_invalid_header,
  output logic                  error_filtered,
  output logic                  error_bad_frame,
  output logic [CNT_WIDTH-1:0]  cnt_rx_ok,
  output logic [CNT_WIDTH-1:0]  cnt_rx_drop
);

  localparam int HDR_BEATS = (ARP_HDR_LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PTR_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(HDR_BEATS - 1);
  localparam int HB = ARP_HDR_LEN * 8;

  arp_rx_state_e state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 hdr_done_q, hdr_done_d;
  logic [HB-1:0]        hdr_q, hdr_d;  // byte 0 in the top byte, big-endian
  logic [47:0]          dest_q, dest_d, src_q, src_d;
  logic [15:0]          type_q, type_d;
  logic                 hdr_ready_q, hdr_ready_d;
  logic                 tready_q, tready_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_et_q, err_et_d, err_inv_q, err_inv_d;
  logic                 err_filt_q, err_filt_d, err_bad_q, err_bad_d;
  logic [CNT_WIDTH-1:0] cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d;
  logic [KEEP_WIDTH-1:0] keep;
  logic                 beat, hdr_fire, hdr_valid, tpa_match;

  assign keep     = KEEP_ENABLE ? s_eth_payload_axis_tkeep : '1;
  assign beat     = s_eth_payload_axis_tvalid && tready_q;
  assign hdr_fire = (state_q == ST_IDLE) && s_eth_hdr_valid && hdr_ready_q;

  // Checks see the header including bytes landing on the current (possibly tlast) beat.
  arp_hdr_check #(.FILTER_ENABLE(FILTER_ENABLE)) u_check (
    .htype     (hdr_d[HB-1  -: 16]),
    .ptype     (hdr_d[HB-17 -: 16]),
    .hlen      (hdr_d[HB-33 -: 8]),
    .plen      (hdr_d[HB-41 -: 8]),
    .oper      (hdr_d[HB-49 -: 16]),
    .tpa       (hdr_d[31:0]),
    .local_ip  (local_ip),
    .hdr_valid (hdr_valid),
    .tpa_match (tpa_match)
  );

  // Header byte capture: byte b lives in beat b/KEEP_WIDTH, lane b%KEEP_WIDTH.
  always_comb begin
    hdr_d      = hdr_q;
    hdr_done_d = hdr_done_q;
    if (hdr_fire) hdr_done_d = 1'b0;
    if ((state_q == ST_HDR) && beat) begin
      for (int b = 0; b < ARP_HDR_LEN; b++) begin
        if ((ptr_q == PTR_W'(b / KEEP_WIDTH)) && keep[b % KEEP_WIDTH]) begin
          hdr_d[(ARP_HDR_LEN-1-b)*8 +: 8] = s_eth_payload_axis_tdata[(b % KEEP_WIDTH)*8 +: 8];
          if (b == ARP_HDR_LEN-1) hdr_done_d = 1'b1;
        end
      end
    end
  end

  // FSM next state, frame verdict, counters and registered ready/busy.
  always_comb begin
    logic finish;
    finish     = 1'b0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    dest_d     = dest_q;
    src_d      = src_q;
    type_d     = type_q;
    valid_d    = valid_q && !m_frame_ready;
    err_et_d   = 1'b0;
    err_inv_d  = 1'b0;
    err_filt_d = 1'b0;
    err_bad_d  = 1'b0;
    cnt_ok_d   = cnt_ok_q;
    cnt_drop_d = cnt_drop_q;

    case (state_q)
      ST_IDLE: begin
        if (hdr_fire) begin
          dest_d  = s_eth_dest_mac;
          src_d   = s_eth_src_mac;
          type_d  = s_eth_type;
          ptr_d   = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (beat) begin
          ptr_d = ptr_q + 1'b1;
          if (s_eth_payload_axis_tlast) finish = 1'b1;
          else if (ptr_q == LAST_BEAT) state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (beat && s_eth_payload_axis_tlast) finish = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      if (!hdr_done_d)                   err_et_d   = 1'b1;
      else if (s_eth_payload_axis_tuser) err_bad_d  = 1'b1;
      else if (!hdr_valid)               err_inv_d  = 1'b1;
      else if (!tpa_match)               err_filt_d = 1'b1;
      else                               valid_d    = 1'b1;
      if (valid_d) begin
        if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + 1'b1;
      end else begin
        if (cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + 1'b1;
      end
    end

    hdr_ready_d = (state_d == ST_IDLE) && !valid_d;
    tready_d    = (state_d == ST_HDR) || (state_d == ST_DROP);
    busy_d      = tready_d;
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hdr_done_q  <= 1'b0;
      hdr_q       <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      hdr_ready_q <= 1'b0;
      tready_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_et_q    <= 1'b0;
      err_inv_q   <= 1'b0;
      err_filt_q  <= 1'b0;
      err_bad_q   <= 1'b0;
      cnt_ok_q    <= '0;
      cnt_drop_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hdr_done_q  <= hdr_done_d;
      hdr_q       <= hdr_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      hdr_ready_q <= hdr_ready_d;
      tready_q    <= tready_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_et_q    <= err_et_d;
      err_inv_q   <= err_inv_d;
      err_filt_q  <= err_filt_d;
      err_bad_q   <= err_bad_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_drop_q  <= cnt_drop_d;
    end
  end

  assign s_eth_hdr_ready                = hdr_ready_q;
  assign s_eth_payload_axis_tready      = tready_q;
  assign m_frame_valid                  = valid_q;
  assign m_eth_dest_mac                 = dest_q;
  assign m_eth_src_mac                  = src_q;
  assign m_eth_type                     = type_q;
  assign m_arp_htype                    = hdr_q[HB-1  -: 16];
  assign m_arp_ptype                    = hdr_q[HB-17 -: 16];
  assign m_arp_hlen                     = hdr_q[HB-33 -: 8];
  assign m_arp_plen                     = hdr_q[HB-41 -: 8];
  assign m_arp_oper                     = hdr_q[HB-49 -: 16];
  assign m_arp_sha                      = hdr_q[159:112];
  assign m_arp_spa                      = hdr_q[111:80];
  assign m_arp_tha                      = hdr_q[79:32];
  assign m_arp_tpa                      = hdr_q[31:0];
  assign busy                           = busy_q;
  assign error_header_early_termination = err_et_q;
  assign error_invalid_header           = err_inv_q;
  assign error_filtered                 = err_filt_q;
  assign error_bad_frame                = err_bad_q;
  assign cnt_rx_ok                      = cnt_ok_q;
  assign cnt_rx_drop                    = cnt_drop_q;

endmodule

// File: tb/tb_arp_eth_rx_filter.sv
// Directed bench: an 8-bit filtering instance and a 64-bit non-filtering,
// 2-bit-counter instance, driven one after the other.
module tb_arp_eth_rx_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // instance a: DATA_WIDTH=8, filter on, 16-bit counters
  logic        a_hv, a_hr, a_tk, a_tv, a_tr, a_tl, a_tu, a_mv, a_mr, a_busy;
  logic        a_eet, a_einv, a_efilt, a_ebad;
  logic [47:0] a_dmac, a_smac, a_mdmac, a_msmac, a_sha, a_tha;
  logic [15:0] a_type, a_mtype, a_htype, a_ptype, a_oper, a_cok, a_cdrop;
  logic [7:0]  a_td, a_hlen, a_plen;
  logic [31:0] a_lip, a_spa, a_tpa;

  // instance b: DATA_WIDTH=64, tkeep on, filter off, 2-bit counters
  logic        b_hv, b_hr, b_tv, b_tr, b_tl, b_tu, b_mv, b_mr, b_busy;
  logic        b_eet, b_einv, b_efilt, b_ebad;
  logic [47:0] b_dmac, b_smac, b_mdmac, b_msmac, b_sha, b_tha;
  logic [15:0] b_type, b_mtype, b_htype, b_ptype, b_oper;
  logic [7:0]  b_tk, b_hlen, b_plen;
  logic [63:0] b_td;
  logic [31:0] b_lip, b_spa, b_tpa;
  logic [1:0]  b_cok, b_cdrop;

  arp_eth_rx_filter #(.DATA_WIDTH(8), .FILTER_ENABLE(1'b1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(a_hv), .s_eth_hdr_ready(a_hr),
    .s_eth_dest_mac(a_dmac), .s_eth_src_mac(a_smac), .s_eth_type(a_type),
    .s_eth_payload_axis_tdata(a_td), .s_eth_payload_axis_tkeep(a_tk),
    .s_eth_payload_axis_tvalid(a_tv), .s_eth_payload_axis_tready(a_tr),
    .s_eth_payload_axis_tlast(a_tl), .s_eth_payload_axis_tuser(a_tu),
    .local_ip(a_lip), .m_frame_valid(a_mv), .m_frame_ready(a_mr),
    .m_eth_dest_mac(a_mdmac), .m_eth_src_mac(a_msmac), .m_eth_type(a_mtype),
    .m_arp_htype(a_htype), .m_arp_ptype(a_ptype), .m_arp_hlen(a_hlen),
    .m_arp_plen(a_plen), .m_arp_oper(a_oper), .m_arp_sha(a_sha),
    .m_arp_spa(a_spa), .m_arp_tha(a_tha), .m_arp_tpa(a_tpa), .busy(a_busy),
    .error_header_early_termination(a_eet), .error_invalid_header(a_einv),
    .error_filtered(a_efilt), .error_bad_frame(a_ebad),
    .cnt_rx_ok(a_cok), .cnt_rx_drop(a_cdrop)
  );

  arp_eth_rx_filter #(.DATA_WIDTH(64), .KEEP_ENABLE(1'b1), .FILTER_ENABLE(1'b0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(b_hv), .s_eth_hdr_ready(b_hr),
    .s_eth_dest_mac(b_dmac), .s_eth_src_mac(b_smac), .s_eth_type(b_type),
    .s_eth_payload_axis_tdata(b_td), .s_eth_payload_axis_tkeep(b_tk),
    .s_eth_payload_axis_tvalid(b_tv), .s_eth_payload_axis_tready(b_tr),
    .s_eth_payload_axis_tlast(b_tl), .s_eth_payload_axis_tuser(b_tu),
    .local_ip(b_lip), .m_frame_valid(b_mv), .m_frame_ready(b_mr),
    .m_eth_dest_mac(b_mdmac), .m_eth_src_mac(b_msmac), .m_eth_type(b_mtype),
    .m_arp_htype(b_htype), .m_arp_ptype(b_ptype), .m_arp_hlen(b_hlen),
    .m_arp_plen(b_plen), .m_arp_oper(b_oper), .m_arp_sha(b_sha),
    .m_arp_spa(b_spa), .m_arp_tha(b_tha), .m_arp_tpa(b_tpa), .busy(b_busy),
    .error_header_early_termination(b_eet), .error_invalid_header(b_einv),
    .error_filtered(b_efilt), .error_bad_frame(b_ebad),
    .cnt_rx_ok(b_cok), .cnt_rx_drop(b_cdrop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [223:0] mk_hdr(input logic [15:0] htype, input logic [15:0] ptype,
                                          input logic [7:0] hlen, input logic [7:0] plen,
                                          input logic [15:0] oper, input logic [47:0] sha,
                                          input logic [31:0] spa, input logic [47:0] tha,
                                          input logic [31:0] tpa);
    return {htype, ptype, hlen, plen, oper, sha, spa, tha, tpa};
  endfunction

  // Header handshake on instance a, bounded wait for ready.
  task automatic a_hdr(input logic [47:0] dmac);
    a_hv = 1'b1; a_dmac = dmac; a_smac = 48'h0A0B0C0D0E0F; a_type = 16'h0806;
    for (int k = 0; k < 60; k++) begin
      if (a_hr) break;
      tick();
    end
    chk("a_hdr_ready_wait", 64'(a_hr), 64'd1);
    tick();
    a_hv = 1'b0;
  endtask

  // One byte per beat; bytes past the header are zero padding.
  task automatic a_pay(input logic [223:0] h, input int n, input logic user, input logic last);
    for (int i = 0; i < n; i++) begin
      a_td = (i < 28) ? h[(27-i)*8 +: 8] : 8'h00;
      a_tv = 1'b1;
      a_tl = last && (i == n-1);
      a_tu = user && (i == n-1);
      tick();
    end
    a_tv = 1'b0; a_tl = 1'b0; a_tu = 1'b0;
  endtask

  task automatic b_hdr();
    b_hv = 1'b1; b_dmac = 48'hFFFFFFFFFFFF; b_smac = 48'h112233445566; b_type = 16'h0806;
    for (int k = 0; k < 60; k++) begin
      if (b_hr) break;
      tick();
    end
    chk("b_hdr_ready_wait", 64'(b_hr), 64'd1);
    tick();
    b_hv = 1'b0;
  endtask

  task automatic b_pay(input logic [223:0] h, input int n, input logic [7:0] lastkeep);
    for (int j = 0; j < n; j++) begin
      for (int l = 0; l < 8; l++) begin
        b_td[l*8 +: 8] = ((j*8 + l) < 28) ? h[(27-(j*8+l))*8 +: 8] : 8'h00;
      end
      b_tk = (j == n-1) ? lastkeep : 8'hFF;
      b_tv = 1'b1;
      b_tl = (j == n-1);
      tick();
    end
    b_tv = 1'b0; b_tl = 1'b0;
  endtask

  initial begin
    logic [223:0] h1, h3, h4, h6;
    h1 = mk_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'h020000000001, 32'hC0A80101, 48'h0, 32'hC0A80164);
    h3 = mk_hdr(16'h0001, 16'h0800, 8'd8, 8'd4, 16'h0001, 48'h020000000001, 32'hC0A80101, 48'h0, 32'hC0A80164);
    h4 = mk_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'h020000000001, 32'h0A000009, 48'h0, 32'h0A000002);
    h6 = mk_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002, 48'h02AABBCCDDEE, 32'h0A000007, 48'h0, 32'h0A000002);

    a_hv = 0; a_dmac = 0; a_smac = 0; a_type = 0; a_td = 0; a_tk = 1; a_tv = 0; a_tl = 0; a_tu = 0;
    a_lip = 32'hC0A80164; a_mr = 0;
    b_hv = 0; b_dmac = 0; b_smac = 0; b_type = 0; b_td = 0; b_tk = 0; b_tv = 0; b_tl = 0; b_tu = 0;
    b_lip = 32'h0A000001; b_mr = 0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_a_hdr_ready", 64'(a_hr), 64'd0);
    chk("rst_a_valid",     64'(a_mv), 64'd0);
    chk("rst_a_busy",      64'(a_busy), 64'd0);
    chk("rst_a_tready",    64'(a_tr), 64'd0);
    chk("rst_a_cnt_ok",    64'(a_cok), 64'd0);
    chk("rst_a_tpa",       64'(a_tpa), 64'd0);
    chk("rst_b_cnt_ok",    64'(b_cok), 64'd0);
    rst = 1'b0;
    tick();
    chk("a_hdr_ready_after_rst", 64'(a_hr), 64'd1);

    // valid request, 18 padding bytes
    a_hdr(48'hFFFFFFFFFFFF);
    chk("a_tready_after_hdr", 64'(a_tr), 64'd1);
    chk("a_busy_in_hdr",      64'(a_busy), 64'd1);
    a_pay(h1, 46, 1'b0, 1'b1);
    chk("a1_valid",  64'(a_mv), 64'd1);
    chk("a1_htype",  64'(a_htype), 64'h0001);
    chk("a1_ptype",  64'(a_ptype), 64'h0800);
    chk("a1_hlen",   64'(a_hlen), 64'd6);
    chk("a1_plen",   64'(a_plen), 64'd4);
    chk("a1_oper",   64'(a_oper), 64'h0001);
    chk("a1_sha",    64'(a_sha), 64'h020000000001);
    chk("a1_spa",    64'(a_spa), 64'hC0A80101);
    chk("a1_tha",    64'(a_tha), 64'h0);
    chk("a1_tpa",    64'(a_tpa), 64'hC0A80164);
    chk("a1_dmac",   64'(a_mdmac), 64'hFFFFFFFFFFFF);
    chk("a1_smac",   64'(a_msmac), 64'h0A0B0C0D0E0F);
    chk("a1_etype",  64'(a_mtype), 64'h0806);
    chk("a1_errs",   64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h0);
    chk("a1_cnt_ok", 64'(a_cok), 64'd1);
    chk("a1_cnt_drop", 64'(a_cdrop), 64'd0);
    chk("a1_busy",   64'(a_busy), 64'd0);

    // backpressure: second header waits while the output is held
    a_hv = 1'b1; a_dmac = 48'h001122334455;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_hdr_ready", 64'(a_hr), 64'd0);
      chk("bp_valid",     64'(a_mv), 64'd1);
      chk("bp_dmac",      64'(a_mdmac), 64'hFFFFFFFFFFFF);
      chk("bp_tpa",       64'(a_tpa), 64'hC0A80164);
    end
    a_mr = 1'b1;
    tick();
    a_mr = 1'b0;
    chk("bp_valid_clear", 64'(a_mv), 64'd0);
    chk("bp_hdr_ready_up", 64'(a_hr), 64'd1);
    tick();
    a_hv = 1'b0;
    chk("bp_second_accepted", 64'(a_tr), 64'd1);
    chk("bp_second_dmac", 64'(a_mdmac), 64'h001122334455);

    // early termination: tlast on byte 20
    a_pay(h1, 21, 1'b0, 1'b1);
    chk("et_errs",    64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h8);
    chk("et_valid",   64'(a_mv), 64'd0);
    chk("et_cnt_drop", 64'(a_cdrop), 64'd1);
    chk("et_cnt_ok",  64'(a_cok), 64'd1);
    tick();
    chk("et_pulse_one_cycle", 64'(a_eet), 64'd0);

    // hlen = 8
    a_hdr(48'hFFFFFFFFFFFF);
    a_pay(h3, 46, 1'b0, 1'b1);
    chk("inv_errs",     64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h2);
    chk("inv_valid",    64'(a_mv), 64'd0);
    chk("inv_cnt_drop", 64'(a_cdrop), 64'd2);

    // tpa 10.0.0.2 vs local 10.0.0.1
    a_lip = 32'h0A000001;
    a_hdr(48'hFFFFFFFFFFFF);
    a_pay(h4, 46, 1'b0, 1'b1);
    chk("filt_errs",     64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h1);
    chk("filt_valid",    64'(a_mv), 64'd0);
    chk("filt_cnt_drop", 64'(a_cdrop), 64'd3);

    // tuser on tlast beat of an otherwise good frame
    a_lip = 32'hC0A80164;
    a_hdr(48'hFFFFFFFFFFFF);
    a_pay(h1, 46, 1'b1, 1'b1);
    chk("bad_errs",     64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h4);
    chk("bad_cnt_drop", 64'(a_cdrop), 64'd4);
    chk("bad_cnt_ok",   64'(a_cok), 64'd1);

    // reset after 5 payload beats
    a_hdr(48'hFFFFFFFFFFFF);
    a_pay(h1, 5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy",   64'(a_busy), 64'd0);
    chk("mid_rst_tready", 64'(a_tr), 64'd0);
    chk("mid_rst_errs",   64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h0);
    chk("mid_rst_cnt_drop", 64'(a_cdrop), 64'd0);
    chk("mid_rst_tpa",    64'(a_tpa), 64'd0);
    tick();
    chk("mid_rst_hdr_ready", 64'(a_hr), 64'd1);

    // tlast exactly on byte 27
    a_hdr(48'hFFFFFFFFFFFF);
    a_pay(h1, 28, 1'b0, 1'b1);
    chk("b27_valid",  64'(a_mv), 64'd1);
    chk("b27_tpa",    64'(a_tpa), 64'hC0A80164);
    chk("b27_errs",   64'({a_eet, a_ebad, a_einv, a_efilt}), 64'h0);
    chk("b27_busy",   64'(a_busy), 64'd0);
    chk("b27_cnt_ok", 64'(a_cok), 64'd1);

    // 64-bit: 4 beats, last tkeep 0x0F, tpa mismatch with filter off
    b_hdr();
    b_pay(h6, 4, 8'h0F);
    chk("w64_valid", 64'(b_mv), 64'd1);
    chk("w64_tpa",   64'(b_tpa), 64'h0A000002);
    chk("w64_spa",   64'(b_spa), 64'h0A000007);
    chk("w64_sha",   64'(b_sha), 64'h02AABBCCDDEE);
    chk("w64_oper",  64'(b_oper), 64'h0002);
    chk("w64_errs",  64'({b_eet, b_ebad, b_einv, b_efilt}), 64'h0);
    chk("w64_cnt_ok", 64'(b_cok), 64'd1);

    // four more accepted frames saturate the 2-bit counter at 3
    b_mr = 1'b1;
    for (int f = 0; f < 4; f++) begin
      b_hdr();
      b_pay(h6, 4, 8'h0F);
      chk("sat_valid", 64'(b_mv), 64'd1);
    end
    chk("sat_cnt_ok",   64'(b_cok), 64'd3);
    chk("sat_cnt_drop", 64'(b_cdrop), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
